// File: rtl/iob_mem_model.sv
// IOb subordinate memory model: byte-enable word array with pipelined read
// latency, periodic ready back-pressure and saturating transfer counters.
module iob_mem_model #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 2,
  parameter int STALL_N = 0,
  parameter int CNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_ready_o,
  input  logic                clr_cnt_i,
  output logic [CNT_W-1:0]    rd_cnt_o,
  output logic [CNT_W-1:0]    wr_cnt_o
);
  localparam int NB_W  = $clog2(DATA_W/8);
  localparam int WI_W  = ADDR_W - NB_W;
  localparam int DEPTH = 2**WI_W;
  localparam int SW    = (STALL_N > 0) ? $clog2(STALL_N+1) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [WI_W-1:0]   widx;
  logic              ready, acc, rd_acc, wr_acc;
  logic [SW-1:0]     stall_q, stall_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [RD_LAT-1:0]             vld_pipe_q;
  logic [RD_LAT-1:0][DATA_W-1:0] dat_pipe_q;

  assign widx   = iob_addr_i[ADDR_W-1:NB_W];
  assign ready  = cke_i & (stall_q == SW'(STALL_N));
  assign acc    = iob_valid_i & ready;
  assign wr_acc = acc & (|iob_wstrb_i);
  assign rd_acc = acc & ~(|iob_wstrb_i);

  generate
    if (NB_W > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^iob_addr_i[NB_W-1:0];
    end
  endgenerate

  // Ready is granted only on the last slot of each STALL_N+1 window.
  assign stall_d = (stall_q == SW'(STALL_N)) ? '0 : stall_q + SW'(1);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  stall_q <= '0;
    else if (cke_i) stall_q <= stall_d;
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (clr_cnt_i) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (rd_acc && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
      if (wr_acc && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (cke_i) begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Array contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (iob_wstrb_i[b]) mem_q[widx][8*b +: 8] <= iob_wdata_i[8*b +: 8];
    end
  end

  // Data stages load only behind a valid, so the last stage holds old rdata.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else if (cke_i) begin
      vld_pipe_q[0] <= rd_acc;
      if (rd_acc) dat_pipe_q[0] <= mem_q[widx];
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
    end
  end

  assign iob_ready_o  = ready;
  assign iob_rvalid_o = vld_pipe_q[RD_LAT-1];
  assign iob_rdata_o  = dat_pipe_q[RD_LAT-1];
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_iob_mem_model.sv
// Bench for iob_mem_model: randomized and directed traffic checked against a
// transaction-level model (word array plus queue of timed read returns).
module tb_iob_mem_model;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cke, valid, clr;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rvalid, ready;
  logic [31:0] rdata;
  logic [2:0]  rd_cnt, wr_cnt;

  logic        s_valid;
  logic [11:0] s_addr;
  logic        s_rvalid, s_ready_o;
  logic [31:0] s_rdata;
  logic [15:0] s_rd_cnt, s_wr_cnt;

  always #5 clk = ~clk;

  iob_mem_model #(.ADDR_W(12), .DATA_W(32), .RD_LAT(LAT), .STALL_N(0), .CNT_W(3)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .iob_valid_i(valid),
    .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_rvalid_o(rvalid), .iob_rdata_o(rdata), .iob_ready_o(ready),
    .clr_cnt_i(clr), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt));

  iob_mem_model #(.ADDR_W(12), .DATA_W(32), .RD_LAT(2), .STALL_N(3), .CNT_W(16)) sdut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(1'b1), .iob_valid_i(s_valid),
    .iob_addr_i(s_addr), .iob_wdata_i(32'h0), .iob_wstrb_i(4'h0),
    .iob_rvalid_o(s_rvalid), .iob_rdata_o(s_rdata), .iob_ready_o(s_ready_o),
    .clr_cnt_i(1'b0), .rd_cnt_o(s_rd_cnt), .wr_cnt_o(s_wr_cnt));

  typedef struct {int due; logic [31:0] d;} rd_t;

  int          total = 0, bad = 0;
  logic [31:0] m_mem [1024];
  rd_t         m_q[$];
  int          m_cyc;
  logic        m_rvalid, m_rdy, s_ready;
  logic [31:0] m_rdata;
  logic [2:0]  m_rd, m_wr;

  task automatic do_reset();
    arst_n = 1'b0;
    valid = 1'b0; s_valid = 1'b0; clr = 1'b0; cke = 1'b1;
    m_q.delete(); m_rvalid = 1'b0; m_rdata = '0; m_rd = '0; m_wr = '0; m_cyc = 0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  // One clock of main-DUT stimulus plus the model's view of that edge.
  task automatic cyc(input logic v, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic ck, input logic cl);
    logic acc;
    rd_t  e;
    valid = v; addr = a; wdata = d; wstrb = s; cke = ck; clr = cl;
    #2;
    s_ready = ready;
    m_rdy   = ck;
    acc     = v & m_rdy;
    @(posedge clk);
    if (ck) begin
      if (acc && s != 0) begin
        for (int b = 0; b < 4; b++) if (s[b]) m_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
      end else if (acc) begin
        e.due = m_cyc + LAT; e.d = m_mem[a[11:2]];
        m_q.push_back(e);
      end
      if (cl) begin
        m_rd = '0; m_wr = '0;
      end else if (acc) begin
        if (s != 0) begin if (m_wr != 3'd7) m_wr++; end
        else begin if (m_rd != 3'd7) m_rd++; end
      end
      m_cyc++;
      m_rvalid = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
        m_rvalid = 1'b1; m_rdata = m_q[0].d;
        void'(m_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({rvalid, rdata, rd_cnt, wr_cnt} !== 39'h0) begin
      bad++; $display("FAIL reset_outs got=%h exp=0", {rvalid, rdata, rd_cnt, wr_cnt});
    end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++;
    if (s_ready_o !== 1'b0) begin bad++; $display("FAIL reset_stall_ready got=%b exp=0", s_ready_o); end
    total++;
    if ({s_rvalid, s_rd_cnt} !== 17'h0) begin bad++; $display("FAIL reset_stall_outs got=%h exp=0", {s_rvalid, s_rd_cnt}); end
  endtask

  task automatic test_write_read();
    int pulses = 0, at = -1;
    logic [31:0] got = '0;
    for (int j = 0; j < LAT + 4; j++) begin
      if (j == 0)      cyc(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
      else if (j == 1) cyc(1'b1, 12'h010, 32'h0, 4'h0, 1'b1, 1'b0);
      else             cyc(1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      if (j < 2) begin
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL wr_rd_ready j=%0d got=%b exp=1", j, s_ready); end
      end
      total++;
      if ({s_ready, rvalid, rdata, rd_cnt, wr_cnt} !== {m_rdy, m_rvalid, m_rdata, m_rd, m_wr}) begin
        bad++; $display("FAIL wr_rd_outs j=%0d got=%h exp=%h", j,
          {s_ready, rvalid, rdata, rd_cnt, wr_cnt}, {m_rdy, m_rvalid, m_rdata, m_rd, m_wr});
      end
      if (rvalid) begin pulses++; at = j + 1; got = rdata; end
    end
    total++;
    if (pulses !== 1 || at !== 1 + LAT) begin bad++; $display("FAIL wr_rd_timing pulses=%0d at=%0d exp 1 at %0d", pulses, at, 1 + LAT); end
    total++;
    if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data got=%h exp=deadbeef", got); end
    total++;
    if ({rd_cnt, wr_cnt} !== {3'd1, 3'd1}) begin bad++; $display("FAIL wr_rd_cnt got=%0d/%0d exp=1/1", rd_cnt, wr_cnt); end
  endtask

  task automatic test_byte_en();
    cyc(1'b1, 12'h020, 32'h11223344, 4'hF, 1'b1, 1'b0);
    cyc(1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0);
    cyc(1'b1, 12'h020, 32'h0, 4'h0, 1'b1, 1'b0);
    for (int j = 0; j < LAT - 1; j++) cyc(1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    total++;
    if ({rvalid, rdata} !== {1'b1, 32'h11BB33DD}) begin bad++; $display("FAIL byte_en got=%b/%h exp=1/11bb33dd", rvalid, rdata); end
    total++;
    if ({rvalid, rdata} !== {m_rvalid, m_rdata}) begin bad++; $display("FAIL byte_en_model got=%h exp=%h", {rvalid, rdata}, {m_rvalid, m_rdata}); end
    cyc(1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    total++;
    if ({rvalid, rdata} !== {1'b0, 32'h11BB33DD}) begin bad++; $display("FAIL byte_en_hold got=%b/%h exp=0/11bb33dd", rvalid, rdata); end
  endtask

  task automatic test_back_to_back();
    int n = 0, first_at = -1;
    for (int i = 0; i < 64; i++) cyc(1'b1, 12'(i * 4), 32'(i), 4'hF, 1'b1, 1'b0);
    for (int j = 0; j < 8 + LAT + 1; j++) begin
      cyc(j < 8, 12'(j * 4), 32'h0, 4'h0, 1'b1, 1'b0);
      total++;
      if ({s_ready, rvalid, rdata, rd_cnt, wr_cnt} !== {m_rdy, m_rvalid, m_rdata, m_rd, m_wr}) begin
        bad++; $display("FAIL b2b_outs j=%0d got=%h exp=%h", j,
          {s_ready, rvalid, rdata, rd_cnt, wr_cnt}, {m_rdy, m_rvalid, m_rdata, m_rd, m_wr});
      end
      if (rvalid) begin
        if (first_at < 0) first_at = j + 1;
        total++;
        if (rdata !== 32'(n) || j + 1 !== first_at + n) begin
          bad++; $display("FAIL b2b_seq n=%0d got=%h at=%0d exp=%h at=%0d", n, rdata, j + 1, n, first_at + n);
        end
        n++;
      end
    end
    total++;
    if (n !== 8 || first_at !== LAT) begin bad++; $display("FAIL b2b_count got=%0d first=%0d exp=8 first=%0d", n, first_at, LAT); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      cyc($urandom_range(0, 99) < 70, {4'(0), 6'($urandom_range(0, 63)), 2'(0)}, $urandom,
          ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
          $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 4);
      total++;
      if ({s_ready, rvalid, rdata, rd_cnt, wr_cnt} !== {m_rdy, m_rvalid, m_rdata, m_rd, m_wr}) begin
        bad++; $display("FAIL rand_outs j=%0d got=%h exp=%h", j,
          {s_ready, rvalid, rdata, rd_cnt, wr_cnt}, {m_rdy, m_rvalid, m_rdata, m_rd, m_wr});
      end
    end
    for (int j = 0; j < LAT + 1; j++) cyc(1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_inflight();
    int pulses = 0;
    cyc(1'b1, 12'h100, 32'h0BADCAFE, 4'hF, 1'b1, 1'b0);
    cyc(1'b1, 12'h100, 32'h0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 12'h100, 32'h0, 4'h0, 1'b1, 1'b0);
    #2 do_reset();
    for (int j = 0; j < LAT + 2; j++) begin
      cyc(1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      if (rvalid) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL rst_drop pulses=%0d exp=0", pulses); end
    cyc(1'b1, 12'h100, 32'h0, 4'h0, 1'b1, 1'b0);
    for (int j = 0; j < LAT - 1; j++) cyc(1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    total++;
    if ({rvalid, rdata} !== {1'b1, 32'h0BADCAFE}) begin bad++; $display("FAIL rst_keep_mem got=%b/%h exp=1/0badcafe", rvalid, rdata); end
  endtask

  task automatic test_sat_clear();
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 12'(12'h200 + i * 4), 32'(i), 4'hF, 1'b1, 1'b0);
    total++;
    if (wr_cnt !== 3'd7) begin bad++; $display("FAIL sat_wr got=%0d exp=7", wr_cnt); end
    cyc(1'b1, 12'h240, 32'h0, 4'hF, 1'b1, 1'b1);
    total++;
    if ({wr_cnt, rd_cnt} !== 6'h0) begin bad++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", wr_cnt, rd_cnt); end
    cyc(1'b1, 12'h244, 32'h0, 4'hF, 1'b1, 1'b0);
    total++;
    if ({wr_cnt, rd_cnt} !== {m_wr, m_rd}) begin bad++; $display("FAIL clr_after got=%0d/%0d exp=%0d/%0d", wr_cnt, rd_cnt, m_wr, m_rd); end
  endtask

  task automatic test_stall();
    int acc_n = 0;
    logic exp_r, exp_v;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      s_valid = (acc_n < 4);
      s_addr  = 12'(acc_n * 4);
      #2;
      exp_r = (k % 4 == 3);
      exp_v = (k >= 5 && k <= 17 && (k - 5) % 4 == 0);
      total++;
      if (s_ready_o !== exp_r) begin bad++; $display("FAIL stall_ready k=%0d got=%b exp=%b", k, s_ready_o, exp_r); end
      total++;
      if (s_rvalid !== exp_v) begin bad++; $display("FAIL stall_rvalid k=%0d got=%b exp=%b", k, s_rvalid, exp_v); end
      if (exp_r && s_valid) acc_n++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    total++;
    if (s_rd_cnt !== 16'd4) begin bad++; $display("FAIL stall_rd_cnt got=%0d exp=4", s_rd_cnt); end
  endtask

  initial begin
    arst_n = 1'b0; cke = 1'b1; valid = 1'b0; clr = 1'b0;
    addr = '0; wdata = '0; wstrb = '0; s_valid = 1'b0; s_addr = '0;
    test_reset();
    test_write_read();
    test_byte_en();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    test_sat_clear();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
